// File: rtl/result_scoreboard.sv
`default_nettype none
// ============================================================================
// result_scoreboard : grades a processor result stream against an expected-
//                     value ROM; accumulates pass count, half-point score, map
// Revision: 1.0
// ============================================================================
module result_scoreboard #(
  parameter int NUM_CHECKS  = 20,
  parameter int DATA_W      = 32,
  parameter int SKIP_CYCLES = 1,
  parameter int WEIGHT_X2   = 7,
  parameter int SCORE_W     = 16,
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CNT_W = $clog2(NUM_CHECKS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     result,
  input  logic                  result_valid,
  output logic [IDX_W-1:0]      exp_addr,
  input  logic [DATA_W-1:0]     exp_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pass_count,
  output logic [SCORE_W-1:0]    score,
  output logic [NUM_CHECKS-1:0] pass_map,
  output logic                  fail_seen,
  output logic [IDX_W-1:0]      first_fail_idx
);

  localparam int SKW = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
  localparam logic [SKW-1:0]   c_SKIP_LAST = SKW'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(NUM_CHECKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SKIP  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [SKW-1:0]        r_skip_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_pass_count;
  logic [SCORE_W-1:0]    r_score;
  logic [NUM_CHECKS-1:0] r_pass_map;
  logic                  r_fail_seen;
  logic [IDX_W-1:0]      r_first_fail_idx;

  logic                  w_start_run;
  logic                  w_check;
  logic                  w_last;
  logic                  w_match;
  logic [NUM_CHECKS-1:0] w_hit_mask;

  assign w_start_run = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_check     = (r_state == S_CHECK) && result_valid;
  assign w_last      = (r_idx == c_LAST_IDX);
  assign w_match     = (result == exp_data);
  assign w_hit_mask  = NUM_CHECKS'(1) << r_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = (SKIP_CYCLES > 0) ? S_SKIP : S_CHECK;
        end
      end
      S_SKIP: begin
        if (r_skip_cnt == c_SKIP_LAST) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (result_valid && w_last) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Index parks at the last check in DONE so exp_addr stays stable there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_skip_cnt       <= '0;
      r_idx            <= '0;
      r_pass_count     <= '0;
      r_score          <= '0;
      r_pass_map       <= '0;
      r_fail_seen      <= 1'b0;
      r_first_fail_idx <= '0;
    end else if (w_start_run) begin
      r_skip_cnt       <= '0;
      r_idx            <= '0;
      r_pass_count     <= '0;
      r_score          <= '0;
      r_pass_map       <= '0;
      r_fail_seen      <= 1'b0;
      r_first_fail_idx <= '0;
    end else begin
      if (r_state == S_SKIP) begin
        r_skip_cnt <= r_skip_cnt + SKW'(1);
      end
      if (w_check) begin
        if (w_match) begin
          r_pass_map   <= r_pass_map | w_hit_mask;
          r_pass_count <= r_pass_count + CNT_W'(1);
          r_score      <= r_score + SCORE_W'(WEIGHT_X2);
        end else if (!r_fail_seen) begin
          r_fail_seen      <= 1'b1;
          r_first_fail_idx <= r_idx;
        end
        if (!w_last) begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign exp_addr       = r_idx;
  assign busy           = (r_state == S_SKIP) || (r_state == S_CHECK);
  assign done           = (r_state == S_DONE);
  assign pass_count     = r_pass_count;
  assign score          = r_score;
  assign pass_map       = r_pass_map;
  assign fail_seen      = r_fail_seen;
  assign first_fail_idx = r_first_fail_idx;

endmodule
`default_nettype wire

// File: tb/tb_result_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_result_scoreboard : table-driven directed checks of result_scoreboard
// Revision: 1.0
// ============================================================================
module tb_result_scoreboard;

  localparam int N = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] result;
  logic        result_valid;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        busy;
  logic        done;
  logic [4:0]  pass_count;
  logic [15:0] score;
  logic [19:0] pass_map;
  logic        fail_seen;
  logic [4:0]  first_fail_idx;

  logic [31:0] rom [N];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [19:0] bad_mask;
    int          gap_before;
    int          gap_len;
    int          start_at;
    logic [4:0]  exp_pc;
    logic [15:0] exp_score;
    logic [19:0] exp_map;
    logic        exp_fs;
    logic [4:0]  exp_ffi;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  assign exp_data = rom[exp_addr];

  result_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .result         (result),
    .result_valid   (result_valid),
    .exp_addr       (exp_addr),
    .exp_data       (exp_data),
    .busy           (busy),
    .done           (done),
    .pass_count     (pass_count),
    .score          (score),
    .pass_map       (pass_map),
    .fail_seen      (fail_seen),
    .first_fail_idx (first_fail_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".done"},  32'(done), 0);
    chk({tag, ".pc"},    32'(pass_count), 0);
    chk({tag, ".score"}, 32'(score), 0);
    chk({tag, ".map"},   32'(pass_map), 0);
    chk({tag, ".fs"},    32'(fail_seen), 0);
    chk({tag, ".ffi"},   32'(first_fail_idx), 0);
    chk({tag, ".addr"},  32'(exp_addr), 0);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    string t;
    t = $sformatf("v%0d", vi);
    start = 1'b1; result_valid = 1'b0;
    tick;
    start = 1'b0;
    chk({t, ".busy_k1"}, 32'(busy), 1);
    chk({t, ".done_k1"}, 32'(done), 0);
    chk({t, ".pc_clr"},  32'(pass_count), 0);
    chk({t, ".sc_clr"},  32'(score), 0);
    chk({t, ".map_clr"}, 32'(pass_map), 0);
    chk({t, ".fs_clr"},  32'(fail_seen), 0);
    // Junk with valid and start during SKIP must be ignored.
    result_valid = 1'b1; result = 32'hDEADBEEF; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == v.gap_before) begin
        for (int g = 0; g < v.gap_len; g++) begin
          result_valid = 1'b0; result = $urandom;
          tick;
          chk($sformatf("%s.gap_addr%0d", t, g), 32'(exp_addr), 32'(i));
        end
      end
      chk($sformatf("%s.addr%0d", t, i), 32'(exp_addr), 32'(i));
      chk($sformatf("%s.nodone%0d", t, i), 32'(done), 0);
      result_valid = 1'b1;
      result = v.bad_mask[i] ? (rom[i] ^ 32'h3) : rom[i];
      start = (i == v.start_at);
      tick;
      start = 1'b0;
    end
    result_valid = 1'b0;
    chk({t, ".done"},  32'(done), 1);
    chk({t, ".busy"},  32'(busy), 0);
    chk({t, ".pc"},    32'(pass_count), 32'(v.exp_pc));
    chk({t, ".score"}, 32'(score), 32'(v.exp_score));
    chk({t, ".map"},   32'(pass_map), 32'(v.exp_map));
    chk({t, ".fs"},    32'(fail_seen), 32'(v.exp_fs));
    chk({t, ".ffi"},   32'(first_fail_idx), 32'(v.exp_ffi));
    chk({t, ".addr_done"}, 32'(exp_addr), 32'(N - 1));
    result_valid = 1'b1; result = rom[N-1] ^ 32'h1;
    tick;
    tick;
    result_valid = 1'b0;
    chk({t, ".done_hold"},  32'(done), 1);
    chk({t, ".pc_hold"},    32'(pass_count), 32'(v.exp_pc));
    chk({t, ".score_hold"}, 32'(score), 32'(v.exp_score));
    chk({t, ".map_hold"},   32'(pass_map), 32'(v.exp_map));
    chk({t, ".addr_hold"},  32'(exp_addr), 32'(N - 1));
  endtask

  initial begin
    for (int i = 0; i < N; i++) rom[i] = 32'hA5A50000 + 32'(i) * 32'h01010101;
    rom[9] = 32'hFFFFFFFE;

    vecs[0] = '{20'h00000, -1, 0, -1, 5'd20, 16'd140, 20'hFFFFF, 1'b0, 5'd0};
    vecs[1] = '{20'h00200, -1, 0, -1, 5'd19, 16'd133, 20'hFFDFF, 1'b1, 5'd9};
    vecs[2] = '{20'h08008, -1, 0, -1, 5'd18, 16'd126, 20'hF7FF7, 1'b1, 5'd3};
    vecs[3] = '{20'h00000,  6, 3, -1, 5'd20, 16'd140, 20'hFFFFF, 1'b0, 5'd0};
    vecs[4] = '{20'h00000, -1, 0,  7, 5'd20, 16'd140, 20'hFFFFF, 1'b0, 5'd0};
    vecs[5] = '{20'h80001, -1, 0, -1, 5'd18, 16'd126, 20'h7FFFE, 1'b1, 5'd0};

    // Reset held together with start: reset must win.
    reset = 1'b0; start = 1'b1; result_valid = 1'b0; result = '0;
    tick;
    tick;
    chk_zero("rst");
    reset = 1'b1; start = 1'b0;
    tick;
    chk("rst.idle_busy", 32'(busy), 0);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

    // Reset in the middle of CHECK, then a fresh full run.
    start = 1'b1;
    tick;
    start = 1'b0; result_valid = 1'b1; result = 32'h0;
    tick;
    for (int i = 0; i <= 10; i++) begin
      result = rom[i];
      tick;
    end
    result_valid = 1'b0;
    chk("mid.pc11", 32'(pass_count), 11);
    chk("mid.addr11", 32'(exp_addr), 11);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk_zero("mid_rst");
    tick;
    chk("mid.idle", 32'(busy), 0);
    run_vec(vecs[0], 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_scoreboard.md
# result_scoreboard

Synthesizable scoreboard that sits directly downstream of the single-cycle processor's `Result` port. It compares the per-instruction result stream against an expected-value table held in an external combinational ROM and accumulates a pass count, a weighted score and a per-check pass map. This lets the directed program be graded on-chip or in any bench without hand-written per-cycle checks.

## Interface
- `NUM_CHECKS`, 20: number of results graded per run (≥1).
- `DATA_W`, 32: result width.
- `SKIP_CYCLES`, 1: cycles ignored after `start` before the first check (covers processor reset/fetch alignment).
- `WEIGHT_X2`, 7: points per passing check, in half-points (7 = 3.5 points).
- `SCORE_W`, 16: score output width.

Ports (`IDX_W` = clog2(`NUM_CHECKS`), `CNT_W` = clog2(`NUM_CHECKS`+1)):
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `result`  in  `DATA_W`  processor `Result` value.
- `result_valid`  in  1  `result` holds a retired instruction's value this cycle.
- `exp_addr`  out  `IDX_W`  index into the expected-value ROM; equals the current check index.
- `exp_data`  in  `DATA_W`  expected value for `exp_addr`, combinational, same cycle.
- `busy`  out  1  high in SKIP and CHECK.
- `done`  out  1  high in DONE.
- `pass_count`  out  `CNT_W`  number of matching checks this run.
- `score`  out  `SCORE_W`  `pass_count`×`WEIGHT_X2`, in half-points.
- `pass_map`  out  `NUM_CHECKS`  bit i = check i matched.
- `fail_seen`  out  1  at least one mismatch this run.
- `first_fail_idx`  out  `IDX_W`  index of the first mismatch; valid only when `fail_seen`=1.

## Operation
- FSM states: IDLE, SKIP, CHECK, DONE.
- Reset (`reset`=0 at an edge) puts the block in IDLE from any state, including mid-run. Every output register clears to 0: `busy`, `done`, `pass_count`, `score`, `pass_map`, `fail_seen`, `first_fail_idx`, and the index, so `exp_addr`=0.
- IDLE or DONE with `start`=1:
  - Clear `pass_count`, `score`, `pass_map`, `fail_seen`, `first_fail_idx` and the index.
  - Go to SKIP if `SKIP_CYCLES`>0, else go to CHECK.
- SKIP:
  - Lasts exactly `SKIP_CYCLES` cycles, then goes to CHECK.
  - `result_valid` and `start` are ignored.
- CHECK, on a cycle with `result_valid`=1 (check i = current index):
  - On match (`result`==`exp_data`, full `DATA_W` compare): set `pass_map[i]`, increment `pass_count`, add `WEIGHT_X2` to `score`.
  - On mismatch: leave counters unchanged. If `fail_seen`=0, set `fail_seen`=1 and `first_fail_idx`=i.
  - If i=`NUM_CHECKS`-1, go to DONE. Otherwise increment the index.
- CHECK, on a cycle with `result_valid`=0: hold all state. A gap never consumes a check.
- `start` is ignored while `busy`=1.
- `score` arithmetic is unsigned and is kept as a running sum, not a multiplier. Its maximum `NUM_CHECKS`×`WEIGHT_X2` must fit in `SCORE_W`; the block never wraps under legal parameters.
- DONE:
  - All results hold until the next `start` or reset.
  - The index stays at `NUM_CHECKS`-1.

## Timing
- `start` sampled at edge k: `busy`=1 from cycle k+1.
- First check uses the result present in cycle k+1+`SKIP_CYCLES`, if valid.
- Latency of each check is one cycle: a result compared at edge n is reflected in `pass_count`, `score`, `pass_map` and `fail_seen` after edge n.
- After the last valid check at edge n: `done`=1 and `busy`=0 from cycle n+1. `done` stays high as a level, not a pulse.
- `exp_addr` updates at the same edge as the index, so the ROM lookup for check i+1 is ready the cycle after check i.
- Reset asserted in the same cycle as `start`: reset wins.

## Test plan
- All 20 results match the table, `result_valid` held 1 → `pass_count`=20, `score`=140, `pass_map`=20'hFFFFF, `fail_seen`=0, `done`=1 exactly 1+`SKIP_CYCLES`+20 cycles after `start`.
- Result 9 driven as 32'hFFFFFFFD instead of the expected 32'hFFFFFFFE, all others match → `pass_count`=19, `score`=133, `pass_map` bit 9 = 0, `fail_seen`=1, `first_fail_idx`=9.
- Mismatches at checks 3 and 15 → `first_fail_idx`=3 (not 15), `pass_count`=18, `score`=126.
- `result_valid` deasserted for 3 cycles between checks 5 and 6, with junk on `result` during the gap → identical results to the all-match run; `done` arrives 3 cycles later.
- Reset pulsed low after check 10 → all outputs 0 and state IDLE next cycle. A new `start` then grades a full 20 checks from index 0.
- `start` pulsed mid-CHECK → ignored, run unaffected. `start` in DONE → counters and `pass_map` clear on the next cycle, and a second run with all matches gives `score`=140 again.
